cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Shares the single common data bus (CDB) among the functional units (ALU, mult, div, load).
//  Each unit presents a registered result packet and holds it while its stall input is high.
//  Arbiter grants one requester per cycle, round-robin, drives a registered CDB packet to ROB/RAT/RS,
//  and returns per-unit stall so losing units freeze their output registers.
// PARAMETERS
//  NUM_REQ    4   number of requesting functional units (2..8)
//  DATA_W     32  result data width
//  ROB_IDX_W  5   ROB index width
//  PHYS_W     6   physical register address width
// PORTS
//  clk             in   1                  clock
//  rst             in   1                  synchronous active-high reset
//  flush           in   1                  pipeline flush (branch mispredict)
//  req_valid       in   NUM_REQ            unit i has a result packet
//  req_rob_id      in   NUM_REQ*ROB_IDX_W  packed per-unit ROB index
//  req_phys_rd     in   NUM_REQ*PHYS_W     packed per-unit physical rd
//  req_arch_rd     in   NUM_REQ*5          packed per-unit architectural rd
//  req_data        in   NUM_REQ*DATA_W     packed per-unit result
//  stall           out  NUM_REQ            unit i must hold its packet next edge
//  cdb_valid       out  1                  CDB broadcast valid
//  cdb_rob_id      out  ROB_IDX_W          broadcast ROB index
//  cdb_phys_rd     out  PHYS_W             broadcast physical rd
//  cdb_arch_rd     out  5                  broadcast architectural rd
//  cdb_data        out  DATA_W             broadcast data
//  cdb_src         out  $clog2(NUM_REQ)    index of granted unit (debug/ROB)
// BEHAVIOUR
//  Clock clk; reset rst is synchronous, active-high.
//  Reset: all cdb_* outputs 0, rr_ptr = 0; stall is combinational (0 while req_valid = 0).
//  Grant (combinational): first i with req_valid[i] scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//  stall[i] = req_valid[i] & ~grant[i] & ~flush. Unit samples stall at the same edge.
//  CDB register: on each edge, cdb_* <= granted packet, cdb_valid <= |req_valid.
//  If no request, cdb_valid <= 0 and payload <= 0.
//  Latency: packet presented in cycle t appears on CDB in cycle t+1 if granted.
//  rr_ptr update: on a grant to unit g, rr_ptr <= (g+1) mod NUM_REQ (wrap NUM_REQ-1 -> 0).
//  No grant: rr_ptr unchanged.
//  Fairness: a continuously valid requester waits at most NUM_REQ-1 cycles for a grant.
//  flush: cdb_valid <= 0, payload <= 0, stall = 0 for all units that cycle, and rr_ptr is held.
//  Units clear their own packets on flush.
//  flush and rst together: rst wins.
//  Single requester: never stalled; back-to-back packets from one unit are granted every cycle.
//  Requester drops req_valid while stalled (its own flush): it is simply excluded; no state kept.
//  No backpressure from CDB consumers; one broadcast per cycle always accepted.
// CONFIGURATION
//  CDB_ARB_PERF_EN defined:
//   - adds out port perf_stall_cnt [NUM_REQ*32], one counter per unit, +1 each cycle stall[i] = 1.
//   - adds out port perf_grant_cnt [NUM_REQ*32], one counter per unit, +1 per grant.
//   - counters reset to 0 on rst, are not cleared by flush, and wrap at 2^32.
//  CDB_ARB_PERF_EN not defined: ports and counters absent; otherwise identical behaviour.
// TESTING
//  1. Reset then idle: cdb_valid = 0, stall = 4'b0000, cdb_data = 0 for 10 cycles.
//  2. Only unit 1 valid (rob 3, data 32'hDEAD_BEEF) for 3 cycles:
//     - stall = 0.
//     - CDB carries rob 3 / DEAD_BEEF for 3 consecutive cycles starting one cycle later; cdb_src = 1.
//  3. All 4 valid every cycle from rr_ptr = 0: grants 0,1,2,3,0.
//     - stall = 4'b1110, 4'b1101, 4'b1011, 4'b0111, in sequence.
//  4. Units 2 and 3 valid, rr_ptr = 3: unit 3 granted first and unit 2 stalled.
//     - Next cycle rr_ptr = 0 and unit 2 is granted.
//  5. flush while units 0,1 valid: next cycle cdb_valid = 0, stall = 0 during flush, rr_ptr unchanged.
//  6. rst asserted with all units valid: next cycle cdb_valid = 0 and rr_ptr = 0.
//     - With PERF_EN: all counters = 0. After 4 contended cycles, each perf_grant_cnt = 1.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: one functional unit wins per cycle and its packet is
// registered onto the CDB; losers see stall. Optional per-unit perf counters under CDB_ARB_PERF_EN.
module cdb_arbiter #(
   parameter  int NUM_REQ   = 4,
   parameter  int DATA_W    = 32,
   parameter  int ROB_IDX_W = 5,
   parameter  int PHYS_W    = 6,
   localparam int SRC_W     = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*ROB_IDX_W-1:0]  req_rob_id,
   input  logic [NUM_REQ*PHYS_W-1:0]     req_phys_rd,
   input  logic [NUM_REQ*5-1:0]          req_arch_rd,
   input  logic [NUM_REQ*DATA_W-1:0]     req_data,
   output logic [NUM_REQ-1:0]            stall,
   output logic                          cdb_valid,
   output logic [ROB_IDX_W-1:0]          cdb_rob_id,
   output logic [PHYS_W-1:0]             cdb_phys_rd,
   output logic [4:0]                    cdb_arch_rd,
   output logic [DATA_W-1:0]             cdb_data,
   output logic [SRC_W-1:0]              cdb_src
`ifdef CDB_ARB_PERF_EN
   ,
   output logic [NUM_REQ*32-1:0]         perf_stall_cnt,
   output logic [NUM_REQ*32-1:0]         perf_grant_cnt
`endif
);

   logic [ROB_IDX_W-1:0] rob_a  [NUM_REQ];
   logic [PHYS_W-1:0]    phys_a [NUM_REQ];
   logic [4:0]           arch_a [NUM_REQ];
   logic [DATA_W-1:0]    data_a [NUM_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign rob_a[gi]  = req_rob_id[gi*ROB_IDX_W +: ROB_IDX_W];
         assign phys_a[gi] = req_phys_rd[gi*PHYS_W +: PHYS_W];
         assign arch_a[gi] = req_arch_rd[gi*5 +: 5];
         assign data_a[gi] = req_data[gi*DATA_W +: DATA_W];
      end
   endgenerate

   logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [NUM_REQ-1:0] grant;
   logic [SRC_W-1:0]   grant_idx;
   logic               grant_any;
   logic [SRC_W-1:0]   scan_idx;
   logic               bcast;

   // Scan starts at rr_ptr and wraps; first valid requester wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      scan_idx  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx = SRC_W'((int'(rr_ptr_q) + k) % NUM_REQ);
         if (!grant_any && req_valid[scan_idx]) begin
            grant_any        = 1'b1;
            grant_idx        = scan_idx;
            grant[scan_idx]  = 1'b1;
         end
      end
   end

   assign bcast = grant_any & ~flush;
   assign stall = req_valid & ~grant & ~{NUM_REQ{flush}};

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (bcast) begin
         rr_ptr_d = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

   logic                 cdb_valid_q;
   logic [ROB_IDX_W-1:0] cdb_rob_id_q;
   logic [PHYS_W-1:0]    cdb_phys_rd_q;
   logic [4:0]           cdb_arch_rd_q;
   logic [DATA_W-1:0]    cdb_data_q;
   logic [SRC_W-1:0]     cdb_src_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q      <= '0;
         cdb_valid_q   <= 1'b0;
         cdb_rob_id_q  <= '0;
         cdb_phys_rd_q <= '0;
         cdb_arch_rd_q <= '0;
         cdb_data_q    <= '0;
         cdb_src_q     <= '0;
      end else begin
         rr_ptr_q      <= rr_ptr_d;
         cdb_valid_q   <= bcast;
         cdb_rob_id_q  <= bcast ? rob_a[grant_idx]  : '0;
         cdb_phys_rd_q <= bcast ? phys_a[grant_idx] : '0;
         cdb_arch_rd_q <= bcast ? arch_a[grant_idx] : '0;
         cdb_data_q    <= bcast ? data_a[grant_idx] : '0;
         cdb_src_q     <= bcast ? grant_idx         : '0;
      end
   end

   assign cdb_valid   = cdb_valid_q;
   assign cdb_rob_id  = cdb_rob_id_q;
   assign cdb_phys_rd = cdb_phys_rd_q;
   assign cdb_arch_rd = cdb_arch_rd_q;
   assign cdb_data    = cdb_data_q;
   assign cdb_src     = cdb_src_q;

`ifdef CDB_ARB_PERF_EN
   // Counters survive flush and wrap naturally at 2^32.
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_perf
         logic [31:0] stall_cnt_q;
         logic [31:0] grant_cnt_q;
         always_ff @(posedge clk) begin
            if (rst) begin
               stall_cnt_q <= '0;
               grant_cnt_q <= '0;
            end else begin
               stall_cnt_q <= stall_cnt_q + {31'b0, stall[gi]};
               grant_cnt_q <= grant_cnt_q + {31'b0, grant[gi] & bcast};
            end
         end
         assign perf_stall_cnt[gi*32 +: 32] = stall_cnt_q;
         assign perf_grant_cnt[gi*32 +: 32] = grant_cnt_q;
      end
   endgenerate
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter (4 units): expected CDB packets are queued when a request cycle
// is driven and popped when the registered broadcast appears one cycle later.
module tb_cdb_arbiter;

   logic         clk;
   logic         rst;
   logic         flush;
   logic [3:0]   req_valid;
   logic [19:0]  req_rob_id;
   logic [23:0]  req_phys_rd;
   logic [19:0]  req_arch_rd;
   logic [127:0] req_data;
   logic [3:0]   stall;
   logic         cdb_valid;
   logic [4:0]   cdb_rob_id;
   logic [5:0]   cdb_phys_rd;
   logic [4:0]   cdb_arch_rd;
   logic [31:0]  cdb_data;
   logic [1:0]   cdb_src;
`ifdef CDB_ARB_PERF_EN
   logic [127:0] perf_stall_cnt;
   logic [127:0] perf_grant_cnt;
`endif

   cdb_arbiter #(.NUM_REQ(4), .DATA_W(32), .ROB_IDX_W(5), .PHYS_W(6)) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .req_valid   (req_valid),
      .req_rob_id  (req_rob_id),
      .req_phys_rd (req_phys_rd),
      .req_arch_rd (req_arch_rd),
      .req_data    (req_data),
      .stall       (stall),
      .cdb_valid   (cdb_valid),
      .cdb_rob_id  (cdb_rob_id),
      .cdb_phys_rd (cdb_phys_rd),
      .cdb_arch_rd (cdb_arch_rd),
      .cdb_data    (cdb_data),
      .cdb_src     (cdb_src)
`ifdef CDB_ARB_PERF_EN
      ,
      .perf_stall_cnt (perf_stall_cnt),
      .perf_grant_cnt (perf_grant_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        v;
      logic [4:0]  rob;
      logic [5:0]  phys;
      logic [4:0]  arch;
      logic [31:0] data;
      logic [1:0]  src;
   } exp_t;

   exp_t        sb_q[$];
   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   int          rr_m     = 0;
   logic [4:0]  p_rob  [4];
   logic [5:0]  p_phys [4];
   logic [4:0]  p_arch [4];
   logic [31:0] p_data [4];
   int unsigned m_stall [4];
   int unsigned m_grant [4];

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic rand_pkts();
      for (int i = 0; i < 4; i++) begin
         p_rob[i]  = 5'($urandom);
         p_phys[i] = 6'($urandom);
         p_arch[i] = 5'($urandom);
         p_data[i] = $urandom;
      end
   endtask

   task automatic run_cycle(input logic r, input logic f, input logic [3:0] v);
      exp_t       e;
      exp_t       got;
      int         g;
      int         idx;
      logic [3:0] gmask;
      logic [3:0] exp_stall;
      @(negedge clk);
      rst       = r;
      flush     = f;
      req_valid = v;
      for (int i = 0; i < 4; i++) begin
         req_rob_id[i*5 +: 5]   = p_rob[i];
         req_phys_rd[i*6 +: 6]  = p_phys[i];
         req_arch_rd[i*5 +: 5]  = p_arch[i];
         req_data[i*32 +: 32]   = p_data[i];
      end
      #1;
      g = -1;
      for (int k = 0; k < 4; k++) begin
         idx = (rr_m + k) % 4;
         if (g < 0 && v[idx]) g = idx;
      end
      gmask     = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      exp_stall = v & ~gmask & {4{~f}};
      check_val("stall", 64'(stall), 64'(exp_stall));
      e = '0;
      if (!r && !f && g >= 0) begin
         e.v    = 1'b1;
         e.rob  = p_rob[g];
         e.phys = p_phys[g];
         e.arch = p_arch[g];
         e.data = p_data[g];
         e.src  = 2'(g);
      end
      sb_q.push_back(e);
      for (int i = 0; i < 4; i++) begin
         if (r) begin
            m_stall[i] = 0;
            m_grant[i] = 0;
         end else begin
            m_stall[i] += 32'(exp_stall[i]);
            if (!f && g == i) m_grant[i]++;
         end
      end
      if (r) rr_m = 0;
      else if (!f && g >= 0) rr_m = (g + 1) % 4;
      @(posedge clk);
      #1;
      cyc++;
      if (sb_q.size() == 0) begin
         check_val("sb_empty", 64'd1, 64'd0);
      end else begin
         got = sb_q.pop_front();
         check_val("cdb_valid", 64'(cdb_valid),   64'(got.v));
         check_val("cdb_rob",   64'(cdb_rob_id),  64'(got.rob));
         check_val("cdb_phys",  64'(cdb_phys_rd), 64'(got.phys));
         check_val("cdb_arch",  64'(cdb_arch_rd), 64'(got.arch));
         check_val("cdb_data",  64'(cdb_data),    64'(got.data));
         check_val("cdb_src",   64'(cdb_src),     64'(got.src));
      end
`ifdef CDB_ARB_PERF_EN
      for (int i = 0; i < 4; i++) begin
         check_val("perf_stall", 64'(perf_stall_cnt[i*32 +: 32]), 64'(m_stall[i]));
         check_val("perf_grant", 64'(perf_grant_cnt[i*32 +: 32]), 64'(m_grant[i]));
      end
`endif
      $display("cyc %0d rst=%b flush=%b req=%b stall=%b cdb_v=%b src=%0d rob=%0d data=%h",
               cyc, r, f, v, exp_stall, cdb_valid, cdb_src, cdb_rob_id, cdb_data);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; req_valid = '0;
      req_rob_id = '0; req_phys_rd = '0; req_arch_rd = '0; req_data = '0;
      for (int i = 0; i < 4; i++) begin
         m_stall[i] = 0;
         m_grant[i] = 0;
      end
      rand_pkts();

      // Reset, then idle bus
      run_cycle(1'b1, 1'b0, 4'b0000);
      run_cycle(1'b1, 1'b0, 4'b0000);
      for (int n = 0; n < 10; n++) run_cycle(1'b0, 1'b0, 4'b0000);

      // Lone requester streams back-to-back
      p_rob[1] = 5'd3; p_data[1] = 32'hDEAD_BEEF; p_phys[1] = 6'd17; p_arch[1] = 5'd9;
      for (int n = 0; n < 3; n++) run_cycle(1'b0, 1'b0, 4'b0010);
      run_cycle(1'b0, 1'b0, 4'b0000);

      // Full contention from rr_ptr = 0
      run_cycle(1'b1, 1'b0, 4'b0000);
      for (int n = 0; n < 5; n++) begin
         rand_pkts();
         run_cycle(1'b0, 1'b0, 4'b1111);
      end

      // Move rr_ptr to 3, then units 2 and 3 contend
      run_cycle(1'b0, 1'b0, 4'b0100);
      run_cycle(1'b0, 1'b0, 4'b1100);
      run_cycle(1'b0, 1'b0, 4'b0100);

      // Flush with units 0,1 valid; pointer must hold
      rand_pkts();
      run_cycle(1'b0, 1'b1, 4'b0011);
      run_cycle(1'b0, 1'b0, 4'b0011);
      run_cycle(1'b0, 1'b0, 4'b0011);

      // Reset wins over flush and live requests
      run_cycle(1'b1, 1'b1, 4'b1111);
      for (int n = 0; n < 4; n++) begin
         rand_pkts();
         run_cycle(1'b0, 1'b0, 4'b1111);
      end

      // Random traffic with occasional flush
      for (int n = 0; n < 60; n++) begin
         rand_pkts();
         run_cycle(1'b0, ($urandom_range(0, 9) == 0), 4'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
